// File: rtl/bw_io_ddr_bscan_ctl_if.sv
// Controller-side bundle for the DDR pad boundary-scan sequencer.
// The test controller drives the request fields and reads back status and captured data.
//   start     request a transaction (1 cycle)
//   abort     cancel an in-flight transaction
//   len       number of chain bits to shift
//   tdi_data  bits shifted into the chain, bit0 first
//   mode_in   requested pad mode_ctrl value
//   hiz_in    requested pad hiz_n value
//   busy      transaction in progress
//   done      1-cycle completion pulse
//   tdo_data  bits captured from the chain tail
interface bw_io_ddr_bscan_ctl_if #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 7
);
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   len;
    logic [MAX_LEN-1:0] tdi_data;
    logic               mode_in;
    logic               hiz_in;
    logic               busy;
    logic               done;
    logic [MAX_LEN-1:0] tdo_data;

    modport master (
        output start, abort, len, tdi_data, mode_in, hiz_in,
        input  busy, done, tdo_data
    );

    modport slave (
        input  start, abort, len, tdi_data, mode_in, hiz_in,
        output busy, done, tdo_data
    );
endinterface

// File: rtl/bw_io_ddr_bscan_ctl.sv
// Boundary-scan sequencer for the DDR pad chain. Each accepted start runs one
// capture -> shift(len) -> update transaction and collects the chain tail into tdo_data.
// Ports:
//   rclk, arst_l   clock and asynchronous active-low reset
//   ctl            controller bundle (slave side): start/abort/len/tdi_data/mode_in/hiz_in in,
//                  busy/done/tdo_data out
//   bso            chain tail serial out
//   bsi            chain head serial in
//   shift_dr, clock_dr, update_dr, mode_ctrl, hiz_n   pad boundary-scan controls
// Optional build macro BW_IO_BSCAN_CHK_EN adds exp_data (in) and err (out): at completion err
// flags a mismatch between the captured bits and exp_data over the shifted length.
//
// state | meaning
// IDLE  | waiting for start, mode_ctrl/hiz_n track their requests
// CAP0  | capture setup, all strobes low
// CAP1  | capture strobe (clock_dr high)
// SH0   | shift data phase, bsi valid, bso sampled on exit
// SH1   | shift strobe (clock_dr high), bit counter advances
// UPD0  | update setup, bsi low
// UPD1  | update strobe (update_dr high)
// DONE  | completion pulse
module bw_io_ddr_bscan_ctl #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 7
) (
    input  logic                   rclk,
    input  logic                   arst_l,
    bw_io_ddr_bscan_ctl_if.slave   ctl,
    input  logic                   bso,
    output logic                   bsi,
    output logic                   shift_dr,
    output logic                   clock_dr,
    output logic                   update_dr,
    output logic                   mode_ctrl,
    output logic                   hiz_n
`ifdef BW_IO_BSCAN_CHK_EN
    ,
    input  logic [MAX_LEN-1:0]     exp_data,
    output logic                   err
`endif
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, CAP0, CAP1, SH0, SH1, UPD0, UPD1, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   len_q, len_nxt;
    logic [MAX_LEN-1:0] tdi_q, tdi_nxt;
    logic [MAX_LEN-1:0] tdo_q, tdo_nxt;
    logic               mode_nxt, hiz_nxt, bsi_nxt;
    logic               shift_nxt, clock_nxt, update_nxt, busy_nxt, done_nxt;
    logic               busy_q, done_q;
    logic               accept;

    assign accept = (state == IDLE) && ctl.start && !ctl.abort;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        tdi_nxt   = tdi_q;
        tdo_nxt   = tdo_q;
        mode_nxt  = mode_ctrl;
        hiz_nxt   = hiz_n;
        bsi_nxt   = 1'b0;

        case (state)
            IDLE: begin
                mode_nxt = ctl.mode_in;
                hiz_nxt  = ctl.hiz_in;
                if (accept) begin
                    len_nxt   = (ctl.len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : ctl.len;
                    tdi_nxt   = ctl.tdi_data;
                    tdo_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = CAP0;
                end
            end
            CAP0: state_nxt = CAP1;
            CAP1: begin
                cnt_nxt   = '0;
                state_nxt = (len_q != '0) ? SH0 : UPD0;
            end
            SH0: begin
                tdo_nxt[cnt[IDX_W-1:0]] = bso;
                state_nxt = SH1;
            end
            SH1: begin
                if ((cnt + 1'b1) < len_q) begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = SH0;
                end else begin
                    state_nxt = UPD0;
                end
            end
            UPD0:    state_nxt = UPD1;
            UPD1:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // abort discards the sample that SH0 would otherwise take on this edge
        if (state != IDLE && ctl.abort) begin
            state_nxt = IDLE;
            tdo_nxt   = tdo_q;
            cnt_nxt   = cnt;
        end

        // outputs are registered from the next state so each strobe lines up with its state
        case (state_nxt)
            SH0:     bsi_nxt = tdi_nxt[cnt_nxt[IDX_W-1:0]];
            SH1:     bsi_nxt = bsi;
            default: bsi_nxt = 1'b0;
        endcase
        shift_nxt  = (state_nxt == SH0) || (state_nxt == SH1);
        clock_nxt  = (state_nxt == CAP1) || (state_nxt == SH1);
        update_nxt = (state_nxt == UPD1);
        done_nxt   = (state_nxt == DONE);
        busy_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            tdi_q     <= '0;
            tdo_q     <= '0;
            mode_ctrl <= 1'b0;
            hiz_n     <= 1'b1;
            bsi       <= 1'b0;
            shift_dr  <= 1'b0;
            clock_dr  <= 1'b0;
            update_dr <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            len_q     <= len_nxt;
            tdi_q     <= tdi_nxt;
            tdo_q     <= tdo_nxt;
            mode_ctrl <= mode_nxt;
            hiz_n     <= hiz_nxt;
            bsi       <= bsi_nxt;
            shift_dr  <= shift_nxt;
            clock_dr  <= clock_nxt;
            update_dr <= update_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

    assign ctl.busy     = busy_q;
    assign ctl.done     = done_q;
    assign ctl.tdo_data = tdo_q;

`ifdef BW_IO_BSCAN_CHK_EN
    logic [MAX_LEN-1:0] len_mask;
    logic               err_nxt;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // UPD1 -> DONE only happens without abort, so an aborted run leaves err untouched
    always_comb begin
        err_nxt = err;
        if (accept) begin
            err_nxt = 1'b0;
        end else if (state == UPD1 && state_nxt == DONE) begin
            err_nxt = |((tdo_q ^ exp_data) & len_mask);
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_bw_io_ddr_bscan_ctl.sv
module tb_bw_io_ddr_bscan_ctl;
    localparam int MAX_LEN = 64;
    localparam int CNT_W   = 7;

    logic rclk = 1'b0;
    logic arst_l = 1'b0;
    always #5 rclk = ~rclk;

    bw_io_ddr_bscan_ctl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) ctl_if ();

    logic bso, bsi, shift_dr, clock_dr, update_dr, mode_ctrl, hiz_n;
`ifdef BW_IO_BSCAN_CHK_EN
    logic [MAX_LEN-1:0] exp_data;
    logic               err;
`endif

    bw_io_ddr_bscan_ctl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .rclk      (rclk),
        .arst_l    (arst_l),
        .ctl       (ctl_if),
        .bso       (bso),
        .bsi       (bsi),
        .shift_dr  (shift_dr),
        .clock_dr  (clock_dr),
        .update_dr (update_dr),
        .mode_ctrl (mode_ctrl),
        .hiz_n     (hiz_n)
`ifdef BW_IO_BSCAN_CHK_EN
        ,
        .exp_data  (exp_data),
        .err       (err)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;

    // one-stage chain model: bso is bsi delayed by one rclk
    logic loop_q = 1'b0;
    logic loop_en = 1'b0;
    logic bso_tie = 1'b0;
    always @(posedge rclk) begin
        cyc    <= cyc + 1;
        loop_q <= bsi;
    end
    assign bso = loop_en ? loop_q : bso_tie;

    int n_clk, n_sh, n_upd, n_done, done_at, n_bsi;
    logic [63:0] bsi_log;
    always @(negedge rclk) begin
        if (clock_dr) n_clk++;
        if (shift_dr) n_sh++;
        if (update_dr) n_upd++;
        if (ctl_if.done) begin
            n_done++;
            done_at = cyc - start_cyc;
        end
        if (shift_dr && !clock_dr && n_bsi < 64) begin
            bsi_log[n_bsi] = bsi;
            n_bsi++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic clear_mon();
        n_clk = 0; n_sh = 0; n_upd = 0; n_done = 0; done_at = -1; n_bsi = 0; bsi_log = '0;
    endtask

    task automatic start_txn(input int l, input logic [63:0] d);
        ctl_if.len      = CNT_W'(l);
        ctl_if.tdi_data = d;
        ctl_if.start    = 1'b1;
        start_cyc       = cyc;
        clear_mon();
        tick();
        ctl_if.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int k = 0;
        while (n_done == 0 && k < limit) begin
            tick();
            k++;
        end
        total++;
        if (n_done == 0) begin
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", name, limit);
        end
        tick();
    endtask

    task automatic test_reset();
        arst_l = 1'b0;
        ctl_if.start = 1'b0; ctl_if.abort = 1'b0; ctl_if.len = '0; ctl_if.tdi_data = '0;
        ctl_if.mode_in = 1'b1; ctl_if.hiz_in = 1'b0;
        clear_mon();
        repeat (3) tick();
        total++;
        if ({bsi, shift_dr, clock_dr, update_dr, mode_ctrl, hiz_n, ctl_if.busy, ctl_if.done} !== 8'b0000_0100) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000100",
                     {bsi, shift_dr, clock_dr, update_dr, mode_ctrl, hiz_n, ctl_if.busy, ctl_if.done});
        end
        total++;
        if (ctl_if.tdo_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_tdo: got %h want 0", ctl_if.tdo_data);
        end
        ctl_if.mode_in = 1'b0; ctl_if.hiz_in = 1'b1;
        @(negedge rclk);
        arst_l = 1'b1;
        repeat (10) tick();
        total++;
        if ({bsi, shift_dr, clock_dr, update_dr, mode_ctrl, hiz_n, ctl_if.busy, ctl_if.done} !== 8'b0000_0100) begin
            bad++;
            $display("FAIL idle_outputs: got %b want 00000100",
                     {bsi, shift_dr, clock_dr, update_dr, mode_ctrl, hiz_n, ctl_if.busy, ctl_if.done});
        end
        total++;
        if (n_clk + n_sh + n_upd + n_done != 0) begin
            bad++;
            $display("FAIL idle_activity: got %0d strobes want 0", n_clk + n_sh + n_upd + n_done);
        end
    endtask

    task automatic test_len8();
        loop_en = 1'b1;
        ctl_if.mode_in = 1'b1; ctl_if.hiz_in = 1'b0;
        tick();
        total++;
        if ({mode_ctrl, hiz_n} !== 2'b10) begin
            bad++;
            $display("FAIL idle_track: got %b want 10", {mode_ctrl, hiz_n});
        end
        start_txn(8, 64'hA5);
        ctl_if.mode_in = 1'b0; ctl_if.hiz_in = 1'b1;
        repeat (3) tick();
        // start while busy must be ignored
        ctl_if.len = CNT_W'(2);
        ctl_if.start = 1'b1;
        tick();
        ctl_if.start = 1'b0;
        total++;
        if ({ctl_if.busy, mode_ctrl, hiz_n} !== 3'b110) begin
            bad++;
            $display("FAIL busy_freeze: got %b want 110", {ctl_if.busy, mode_ctrl, hiz_n});
        end
        wait_done(40, "len8");
        total++;
        if (done_at != 21) begin
            bad++;
            $display("FAIL len8_latency: got %0d want 21", done_at);
        end
        total++;
        if (n_clk != 9 || n_sh != 16 || n_upd != 1 || n_done != 1) begin
            bad++;
            $display("FAIL len8_strobes: clk=%0d sh=%0d upd=%0d done=%0d want 9 16 1 1", n_clk, n_sh, n_upd, n_done);
        end
        total++;
        if (n_bsi != 8 || bsi_log[7:0] !== 8'hA5) begin
            bad++;
            $display("FAIL len8_bsi: got %0d bits %h want 8 bits a5", n_bsi, bsi_log[7:0]);
        end
        total++;
        if (ctl_if.tdo_data !== 64'h4A || ctl_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL len8_tdo: got %h busy=%b want 4a busy=0", ctl_if.tdo_data, ctl_if.busy);
        end
        repeat (3) tick();
        total++;
        if ({mode_ctrl, hiz_n} !== 2'b01 || ctl_if.tdo_data !== 64'h4A) begin
            bad++;
            $display("FAIL len8_after: got mode/hiz %b tdo %h want 01 4a", {mode_ctrl, hiz_n}, ctl_if.tdo_data);
        end
    endtask

    task automatic test_len0();
        loop_en = 1'b0; bso_tie = 1'b1;
        start_txn(0, 64'hFF);
        wait_done(20, "len0");
        total++;
        if (done_at != 5 || n_clk != 1 || n_sh != 0 || n_upd != 1 || n_done != 1) begin
            bad++;
            $display("FAIL len0: at=%0d clk=%0d sh=%0d upd=%0d done=%0d want 5 1 0 1 1",
                     done_at, n_clk, n_sh, n_upd, n_done);
        end
        total++;
        if (ctl_if.tdo_data !== 64'h0) begin
            bad++;
            $display("FAIL len0_tdo: got %h want 0", ctl_if.tdo_data);
        end
    endtask

    task automatic test_clamp();
        loop_en = 1'b1;
        start_txn(100, 64'h0123_4567_89AB_CDEF);
        wait_done(200, "clamp");
        total++;
        if (done_at != 133 || n_clk != 65 || n_sh != 128 || n_upd != 1) begin
            bad++;
            $display("FAIL clamp_strobes: at=%0d clk=%0d sh=%0d upd=%0d want 133 65 128 1",
                     done_at, n_clk, n_sh, n_upd);
        end
        total++;
        if (ctl_if.tdo_data !== 64'h0246_8ACF_1357_9BDE) begin
            bad++;
            $display("FAIL clamp_tdo: got %h want 02468acf13579bde", ctl_if.tdo_data);
        end
    endtask

    task automatic test_abort();
        loop_en = 1'b1;
        start_txn(8, 64'hA5);
        repeat (7) tick();
        total++;
        if ({shift_dr, clock_dr} !== 2'b11) begin
            bad++;
            $display("FAIL abort_in_sh1: got %b want 11", {shift_dr, clock_dr});
        end
        ctl_if.abort = 1'b1;
        tick();
        ctl_if.abort = 1'b0;
        total++;
        if ({ctl_if.busy, shift_dr, clock_dr, update_dr, bsi} !== 5'b0) begin
            bad++;
            $display("FAIL abort_idle: got %b want 00000", {ctl_if.busy, shift_dr, clock_dr, update_dr, bsi});
        end
        total++;
        if (n_upd != 0 || n_done != 0 || ctl_if.tdo_data !== 64'h02) begin
            bad++;
            $display("FAIL abort_partial: upd=%0d done=%0d tdo=%h want 0 0 02", n_upd, n_done, ctl_if.tdo_data);
        end
        start_txn(0, 64'h0);
        total++;
        if (ctl_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_accept: busy=%b want 1", ctl_if.busy);
        end
        wait_done(20, "restart");
        total++;
        if (done_at != 5 || n_upd != 1 || ctl_if.tdo_data !== 64'h0) begin
            bad++;
            $display("FAIL restart: at=%0d upd=%0d tdo=%h want 5 1 0", done_at, n_upd, ctl_if.tdo_data);
        end
        // start and abort together in IDLE: start is dropped
        clear_mon();
        ctl_if.len = CNT_W'(4);
        ctl_if.start = 1'b1; ctl_if.abort = 1'b1;
        tick();
        ctl_if.start = 1'b0; ctl_if.abort = 1'b0;
        repeat (4) tick();
        total++;
        if (ctl_if.busy !== 1'b0 || n_clk != 0) begin
            bad++;
            $display("FAIL start_abort_same: busy=%b clk=%0d want 0 0", ctl_if.busy, n_clk);
        end
    endtask

`ifdef BW_IO_BSCAN_CHK_EN
    task automatic test_chk();
        loop_en = 1'b0; bso_tie = 1'b1;
        exp_data = 64'hFFFF_0000_0000_000F;
        start_txn(4, 64'h0);
        wait_done(30, "chk_pass");
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL chk_match: err=%b want 0", err);
        end
        exp_data = 64'hE;
        start_txn(4, 64'h0);
        wait_done(30, "chk_fail");
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL chk_mismatch: err=%b want 1", err);
        end
        exp_data = 64'hF;
        start_txn(4, 64'h0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL chk_clear: err=%b want 0", err);
        end
        wait_done(30, "chk_clear");
    endtask
`endif

    initial begin
        test_reset();
        test_len8();
        test_len0();
        test_clamp();
        test_abort();
`ifdef BW_IO_BSCAN_CHK_EN
        test_chk();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
